// File: rtl/kbd_grid_cursor_if.sv
// Key-event input and cell-entry output bundle for kbd_grid_cursor.
// master = the cursor block itself, slave = the keyboard/consumer side.
interface kbd_grid_cursor_if;
    logic [7:0] kbd_data;
    logic [2:0] kbd_type;
    logic       kbd_tot;
    logic [4:0] entry_data;
    logic       entry_valid;
    logic       entry_ready;
    logic [4:0] entry_count;
    logic       overflow;

    modport master (
        input  kbd_data, kbd_type, kbd_tot, entry_ready,
        output entry_data, entry_valid, entry_count, overflow
    );

    modport slave (
        output kbd_data, kbd_type, kbd_tot, entry_ready,
        input  entry_data, entry_valid, entry_count, overflow
    );
endinterface

// File: rtl/kbd_grid_cursor.sv
// Keyboard-driven grid cursor with blink phase and a FIFO of selected cell indices.
// Define KBD_GRID_WRAP_EN to make the cursor wrap at grid edges instead of saturating.
module kbd_grid_cursor #(
    parameter int GRID_W       = 6,
    parameter int GRID_H       = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int BLINK_CYCLES = 41000000
) (
    input  logic              clk,
    input  logic              rst,
    kbd_grid_cursor_if.master bus,
    output logic [2:0]        cur_x,
    output logic [1:0]        cur_y,
    output logic              cursor_on
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [2:0]    X_MAX      = 3'(GRID_W - 1);
    localparam logic [1:0]    Y_MAX      = 2'(GRID_H - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

`ifdef KBD_GRID_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // Keys are matched as {extended, scan code}
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_BKSP  = 9'h066;
    localparam logic [8:0] KEY_ESC   = 9'h076;

    typedef enum logic {IDLE, HELD} state_t;
    typedef enum logic [2:0] {
        ACT_NONE, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT, ACT_ENTER, ACT_BKSP, ACT_ESC
    } action_t;

    state_t        state_q, state_d;
    logic [8:0]    held_code_q, held_code_d;
    logic [2:0]    cur_x_q, cur_x_d;
    logic [1:0]    cur_y_q, cur_y_d;
    logic          cursor_on_q, cursor_on_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [4:0]    mem_q [FIFO_DEPTH];

    logic [8:0] key;
    logic       is_make;
    logic       is_break;
    action_t    key_action;
    action_t    action;
    logic       moved;
    logic       pop;
    logic       full;
    logic       push;
    logic       bksp_apply;
    logic [4:0] cell_index;

    always_comb begin
        is_make  = bus.kbd_tot && (bus.kbd_type == 3'd1 || bus.kbd_type == 3'd2);
        is_break = bus.kbd_tot && (bus.kbd_type == 3'd3 || bus.kbd_type == 3'd4);
        key      = {(bus.kbd_type == 3'd2 || bus.kbd_type == 3'd4), bus.kbd_data};
        case (key)
            KEY_UP:    key_action = ACT_UP;
            KEY_DOWN:  key_action = ACT_DOWN;
            KEY_LEFT:  key_action = ACT_LEFT;
            KEY_RIGHT: key_action = ACT_RIGHT;
            KEY_ENTER: key_action = ACT_ENTER;
            KEY_BKSP:  key_action = ACT_BKSP;
            KEY_ESC:   key_action = ACT_ESC;
            default:   key_action = ACT_NONE;
        endcase
    end

    // Typematic suppression: a repeated make of the held key does nothing
    always_comb begin
        state_d     = state_q;
        held_code_d = held_code_q;
        action      = ACT_NONE;
        case (state_q)
            IDLE: begin
                if (is_make && key_action != ACT_NONE) begin
                    action      = key_action;
                    held_code_d = key;
                    state_d     = HELD;
                end
            end
            HELD: begin
                if (is_make && key_action != ACT_NONE && key != held_code_q) begin
                    action      = key_action;
                    held_code_d = key;
                end else if (is_break && key == held_code_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        moved   = 1'b0;
        case (action)
            ACT_UP: begin
                moved   = 1'b1;
                cur_y_d = (cur_y_q == 2'd0) ? (WRAP ? Y_MAX : 2'd0) : cur_y_q - 2'd1;
            end
            ACT_DOWN: begin
                moved   = 1'b1;
                cur_y_d = (cur_y_q == Y_MAX) ? (WRAP ? 2'd0 : Y_MAX) : cur_y_q + 2'd1;
            end
            ACT_LEFT: begin
                moved   = 1'b1;
                cur_x_d = (cur_x_q == 3'd0) ? (WRAP ? X_MAX : 3'd0) : cur_x_q - 3'd1;
            end
            ACT_RIGHT: begin
                moved   = 1'b1;
                cur_x_d = (cur_x_q == X_MAX) ? (WRAP ? 3'd0 : X_MAX) : cur_x_q + 3'd1;
            end
            ACT_ESC: begin
                cur_x_d = 3'd0;
                cur_y_d = 2'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (moved) begin
            blink_cnt_d = '0;
            cursor_on_d = 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            cursor_on_d = ~cursor_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            cursor_on_d = cursor_on_q;
        end
    end

    assign cell_index = ({3'd0, cur_y_q} * 5'(GRID_W)) + {2'd0, cur_x_q};

    // A pop frees the slot a full-FIFO push needs; with one entry left it beats Backspace
    always_comb begin
        full       = (count_q == FULL_COUNT);
        pop        = (count_q != '0) && bus.entry_ready;
        push       = 1'b0;
        bksp_apply = 1'b0;
        overflow_d = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (action == ACT_ESC) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (action == ACT_ENTER) begin
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (action == ACT_BKSP && count_q != '0 && !(pop && count_q == CW'(1))) begin
                bksp_apply = 1'b1;
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end else if (bksp_apply) begin
                tail_d = tail_q - PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop) - CW'(bksp_apply);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            held_code_q <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cursor_on_q <= 1'b1;
            blink_cnt_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_code_q <= held_code_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cursor_on_q <= cursor_on_d;
            blink_cnt_q <= blink_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Slot contents need no reset; entry_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= cell_index;
        end
    end

    assign bus.entry_data  = (count_q != '0) ? mem_q[head_q] : 5'd0;
    assign bus.entry_valid = (count_q != '0);
    assign bus.entry_count = 5'(count_q);
    assign bus.overflow    = overflow_q;
    assign cur_x           = cur_x_q;
    assign cur_y           = cur_y_q;
    assign cursor_on       = cursor_on_q;
endmodule
